// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// A grant is held for a whole packet, capped at MAX_BURST bytes or HOLD_TO idle cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int HOLD_TO   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [2:0]           grant_id,
    output logic                 grant_active,
    output logic [15:0]          frames_sent
);

    // state | meaning
    // IDLE  | no owner; arbitrate, then one cycle with the grant registered
    // SEND  | hand the owner's byte to the transmitter (one cycle)
    // WAIT  | frame on the line, waiting for tx_done
    // HOLD  | owner keeps the lock while its next byte is pending
    typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

    localparam int              HOLD_W    = $clog2(HOLD_TO);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TO - 1);
    localparam logic [7:0]      BURST_MAX = 8'(MAX_BURST);

    state_t              state, state_next;
    logic [2:0]          rr_ptr;
    logic [7:0]          burst_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                last_flag;

    logic                found_hi, found_lo;
    logic [2:0]          idx_hi, idx_lo;
    logic                pick_any;
    logic [2:0]          pick_idx;

    logic                own_valid, own_last;
    logic [7:0]          own_data;
    logic [NUM_REQ-1:0]  own_onehot;

    logic                do_grant, do_send, do_release, enter_hold, hold_tick;

    // Lowest valid index at or above rr_ptr wins; otherwise lowest index below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                if (3'(j) >= rr_ptr) begin
                    found_hi = 1'b1;
                    idx_hi   = 3'(j);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = 3'(j);
                end
            end
        end
    end

    assign pick_any = found_hi | found_lo;
    assign pick_idx = found_hi ? idx_hi : idx_lo;

    always_comb begin
        own_valid  = 1'b0;
        own_last   = 1'b0;
        own_data   = '0;
        own_onehot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id == 3'(j)) begin
                own_valid     = req_valid[j];
                own_last      = req_last[j];
                own_data      = req_data[8*j +: 8];
                own_onehot[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_send    = 1'b0;
        do_release = 1'b0;
        enter_hold = 1'b0;
        hold_tick  = 1'b0;
        tx_start   = 1'b0;
        tx_data    = '0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_active)              state_next = SEND;
                else if (pick_any && !tx_busy) do_grant   = 1'b1;
            end
            SEND: begin
                tx_start   = 1'b1;
                tx_data    = own_data;
                req_ready  = own_onehot;
                do_send    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (last_flag || burst_cnt == BURST_MAX) begin
                        do_release = 1'b1;
                        state_next = IDLE;
                    end else begin
                        enter_hold = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (own_valid) begin
                    state_next = SEND;
                end else if (hold_cnt == '0) begin
                    do_release = 1'b1;
                    state_next = IDLE;
                end else begin
                    hold_tick = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id     <= '0;
            grant_active <= 1'b0;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            hold_cnt     <= '0;
            last_flag    <= 1'b0;
            frames_sent  <= '0;
        end else begin
            if (do_grant) begin
                grant_id     <= pick_idx;
                grant_active <= 1'b1;
                burst_cnt    <= '0;
            end
            if (do_send) begin
                burst_cnt   <= burst_cnt + 8'd1;
                frames_sent <= frames_sent + 16'd1;
                last_flag   <= own_last;
            end
            if (enter_hold) hold_cnt <= HOLD_LOAD;
            if (hold_tick)  hold_cnt <= hold_cnt - HOLD_W'(1);
            if (do_release) begin
                grant_active <= 1'b0;
                grant_id     <= '0;
                rr_ptr       <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter; a packet-level round-robin
// model predicts byte order and start latency, requester and UART BFMs drive the DUT.
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int MB    = 16;
    localparam int HT    = 8;
    localparam int FRAME = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy = 1'b0;
    logic            tx_done = 1'b0;
    logic [2:0]      grant_id;
    logic            grant_active;
    logic [15:0]     frames_sent;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .HOLD_TO(HT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .grant_id(grant_id), .grant_active(grant_active),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;

    logic [7:0] q_d [NR][$];
    logic       q_l [NR][$];

    logic [NR-1:0] s_ready;
    logic          s_start, s_gact, s_done, s_busy;
    logic [7:0]    s_data;
    logic [2:0]    s_gid;

    int          m_rr = 0;
    logic [15:0] m_frames = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            if (q_d[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = q_d[i][0];
                req_last[i]        = q_l[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        q_d[r].push_back(d);
        q_l[r].push_back(l);
    endtask

    // Sample in mid-cycle, then update requester queues and the UART model after the edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        s_ready = req_ready;
        s_start = tx_start;
        s_data  = tx_data;
        s_gid   = grant_id;
        s_gact  = grant_active;
        s_done  = tx_done;
        s_busy  = tx_busy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (s_ready[i] && req_valid[i]) begin
                void'(q_d[i].pop_front());
                void'(q_l[i].pop_front());
            end
        end
        tx_done = 1'b0;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy = 1'b0;
                tx_done = 1'b1;
            end
        end
        if (s_start) begin
            tx_busy  = 1'b1;
            busy_cnt = FRAME;
        end
        drive_reqs();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < NR; i++) begin
            q_d[i].delete();
            q_l[i].delete();
        end
        drive_reqs();
        m_rr     = 0;
        m_frames = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Packet-level model: queues are all loaded up front, so the owner always has its
    // next byte; each new grant starts 3 cycles after the releasing tx_done, each
    // continuation 2 cycles after, and the first one 2 cycles after requests appear.
    task automatic run_traffic(input int l_cyc);
        int         e_g[$];
        logic [7:0] e_d[$];
        bit         e_new[$];
        logic [7:0] cd [NR][$];
        logic       cl [NR][$];
        int g, n, budget, steps, last_done, exp_cyc;
        bit first;
        logic lst;
        for (int i = 0; i < NR; i++) begin
            cd[i] = q_d[i];
            cl[i] = q_l[i];
        end
        do begin
            g = -1;
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && cd[(m_rr + k) % NR].size() > 0) g = (m_rr + k) % NR;
            end
            if (g >= 0) begin
                n = 0;
                lst = 1'b0;
                while (!lst && n < MB && cd[g].size() > 0) begin
                    e_g.push_back(g);
                    e_d.push_back(cd[g].pop_front());
                    lst = cl[g].pop_front();
                    e_new.push_back(n == 0);
                    n++;
                    m_frames++;
                end
                m_rr = (g + 1) % NR;
            end
        end while (g >= 0);

        budget    = 40 + 12 * e_g.size();
        first     = 1'b1;
        last_done = 0;
        steps     = 0;
        do begin
            cycle();
            steps++;
            if (s_done) last_done = cyc;
            if (s_start) begin
                if (e_g.size() == 0) begin
                    chk("extra_start", s_start, 0);
                end else begin
                    exp_cyc = first ? l_cyc + 2 : last_done + (e_new[0] ? 3 : 2);
                    chk("latency", cyc, exp_cyc);
                    chk("grant_id", s_gid, e_g[0]);
                    chk("tx_data", s_data, e_d[0]);
                    chk("req_ready", s_ready, 1 << e_g[0]);
                    chk("grant_active", s_gact, 1);
                    void'(e_g.pop_front());
                    void'(e_d.pop_front());
                    void'(e_new.pop_front());
                    first = 1'b0;
                end
            end else begin
                chk("ready_idle", s_ready, 0);
            end
        end while ((e_g.size() > 0 || s_gact || s_busy) && steps < budget);
        chk("drain", e_g.size(), 0);
        chk("frames", frames_sent, m_frames);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_start && n < budget);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_done && n < budget);
    endtask

    initial begin
        int d_cyc;

        do_reset();
        chk("rst_gact", grant_active, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_frames", frames_sent, 0);

        // single byte from requester 1, then 0 and 2 together (2 must win next)
        push_byte(1, 8'hA5, 1'b1);
        drive_reqs();
        run_traffic(cyc + 1);
        push_byte(0, 8'h10, 1'b1);
        push_byte(2, 8'h20, 1'b1);
        drive_reqs();
        run_traffic(cyc + 1);

        // all four requesting one-byte packets: order 0,1,2,3,0
        do_reset();
        push_byte(0, 8'h01, 1'b1);
        push_byte(0, 8'h05, 1'b1);
        push_byte(1, 8'h02, 1'b1);
        push_byte(2, 8'h03, 1'b1);
        push_byte(3, 8'h04, 1'b1);
        drive_reqs();
        run_traffic(cyc + 1);
        chk("frames_five", frames_sent, 5);

        // 20-byte packet from 2 split by the burst cap, 3 interleaves
        for (int i = 0; i < 20; i++) push_byte(2, 8'(8'h40 + i), i == 19);
        push_byte(3, 8'h77, 1'b1);
        drive_reqs();
        run_traffic(cyc + 1);

        // request while the transmitter is busy
        tx_busy = 1'b1;
        push_byte(1, 8'h5A, 1'b1);
        drive_reqs();
        repeat (5) begin
            cycle();
            chk("busy_nogrant", s_gact, 0);
            chk("busy_nostart", s_start, 0);
        end
        tx_busy = 1'b0;
        run_traffic(cyc + 1);

        // owner stalls mid-packet: forced release after HT cycles in HOLD
        do_reset();
        push_byte(0, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b1);
        drive_reqs();
        wait_start(10);
        chk("hold_start0", s_start, 1);
        chk("hold_data0", s_data, 8'h11);
        chk("hold_gid0", s_gid, 0);
        wait_done(20);
        chk("hold_done", s_done, 1);
        d_cyc = cyc;
        repeat (HT) begin
            cycle();
            chk("hold_noready", s_ready, 0);
        end
        chk("hold_locked", s_gact, 1);
        cycle();
        chk("hold_released", s_gact, 0);
        wait_start(10);
        chk("hold_start1", s_start, 1);
        chk("hold_lat1", cyc, d_cyc + HT + 3);
        chk("hold_gid1", s_gid, 1);
        chk("hold_data1", s_data, 8'h22);

        // reset while a 3-byte packet waits on tx_done
        do_reset();
        push_byte(3, 8'h31, 1'b0);
        push_byte(3, 8'h32, 1'b0);
        push_byte(3, 8'h33, 1'b1);
        drive_reqs();
        wait_start(10);
        chk("mr_start", s_start, 1);
        cycle();
        rst_n = 1'b0;
        #1;
        chk("mr_gact", grant_active, 0);
        chk("mr_gid", grant_id, 0);
        chk("mr_frames", frames_sent, 0);
        chk("mr_start_low", tx_start, 0);
        chk("mr_ready", req_ready, 0);
        for (int i = 0; i < NR; i++) begin
            q_d[i].delete();
            q_l[i].delete();
        end
        busy_cnt = 0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        drive_reqs();
        m_rr     = 0;
        m_frames = '0;
        repeat (2) cycle();
        rst_n   = 1'b1;
        tx_done = 1'b1;
        repeat (6) begin
            cycle();
            chk("stray_nostart", s_start, 0);
        end
        chk("stray_frames", frames_sent, 0);
        chk("stray_gact", grant_active, 0);

        // random packet mixes
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NR; i++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = $urandom_range(1, 20);
                    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
                end
            end
            drive_reqs();
            run_traffic(cyc + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requester ports (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, meaning maximum bytes sent per grant before forced release (1..255).
REQ-003 SHALL have parameter HOLD_TO, default 1024, meaning cycles a locked grant waits for the next byte before forced release (≥2).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester byte available.
REQ-007 SHALL have port req_data, input, 8*NUM_REQ, requester i byte on bits [8i+7:8i].
REQ-008 SHALL have port req_last, input, NUM_REQ, current byte ends requester's packet.
REQ-009 SHALL have port req_ready, output, NUM_REQ, byte consumed when valid and ready both high.
REQ-010 SHALL have port tx_start, output, 1, one-cycle pulse launching a frame on the shared UART transmitter.
REQ-011 SHALL have port tx_data, output, 8, byte for the transmitter, valid while tx_start high.
REQ-012 SHALL have port tx_busy, input, 1, transmitter serialising a frame.
REQ-013 SHALL have port tx_done, input, 1, one-cycle pulse at end of stop bit.
REQ-014 SHALL have port grant_id, output, 3, index of current owner (0 when idle).
REQ-015 SHALL have port grant_active, output, 1, a requester owns the transmitter.
REQ-016 SHALL have port frames_sent, output, 16, count of tx_start pulses, wraps 0xFFFF->0.

Function
REQ-017 SHALL implement FSM states IDLE, SEND, WAIT, HOLD.
REQ-018 IDLE: when any req_valid high and tx_busy low, SHALL select first valid requester searching from rr_ptr upward with wrap NUM_REQ-1->0, register grant_id, set grant_active, clear burst count, go SEND next cycle.
REQ-019 SEND: SHALL assert tx_start=1, tx_data=req_data[grant], req_ready[grant]=1 for exactly one cycle, increment burst count and frames_sent, go WAIT.
REQ-020 SEND: SHALL capture req_last of consumed byte into a last flag.
REQ-021 WAIT: SHALL remain until tx_done; on tx_done go IDLE (release) if last flag set or burst count = MAX_BURST, else HOLD.
REQ-022 HOLD: if req_valid[grant] high SHALL go SEND next cycle; else count cycles, release to IDLE when count reaches HOLD_TO.
REQ-023 Release SHALL clear grant_active, set grant_id=0, and set rr_ptr = (released grant + 1) mod NUM_REQ.
REQ-024 req_ready SHALL be 0 in all states other than SEND, and at most one bit high in any cycle.
REQ-025 Non-granted requesters SHALL see no req_ready while another requester holds the lock, regardless of their req_valid.
REQ-026 Latency: req_valid rising in IDLE with tx_busy low SHALL produce tx_start exactly 2 cycles later.
REQ-027 Back-to-back bytes of one packet: tx_done -> HOLD -> SEND SHALL give tx_start 2 cycles after tx_done.
REQ-028 tx_done in any state other than WAIT SHALL be ignored.
REQ-029 Simultaneous requests: only one SHALL be granted; after release the next valid requester above the released index SHALL win.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, rr_ptr=0, grant_id=0, grant_active=0, tx_start=0, tx_data=0, req_ready=0, frames_sent=0, burst and hold counters 0.
REQ-031 Reset mid-frame SHALL abandon the packet without waiting for tx_done; first grant after reset SHALL search from index 0.

Verification
REQ-032 Single requester 1, one byte 0xA5 with last=1 -> tx_start 2 cycles after valid, tx_data=0xA5, req_ready[1] one cycle, grant released on tx_done, rr_ptr=2.
REQ-033 All four valid continuously, each packet one byte last=1 -> grant order 0,1,2,3,0; frames_sent=5.
REQ-034 Requester 2 sends 20-byte packet with MAX_BURST=16 and requester 3 valid -> 16 bytes from 2, then 3 granted, then 2 resumes.
REQ-035 Requester 0 sends byte 0x11 last=0 then drops valid, HOLD_TO=8 -> release 8 cycles after entering HOLD; waiting requester 1 granted next.
REQ-036 Assert rst_n low during WAIT of a 3-byte packet -> all outputs zero immediately; after release, stray tx_done ignored, frames_sent stays 0.
REQ-037 Request while tx_busy=1 in IDLE -> no grant until tx_busy low, then tx_start 2 cycles later.
